// File: rtl/mixer_audio_pkg.sv
// Shared constants and types for the mixer <-> codec audio paths (DAC playback and ADC capture).
package mixer_audio_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } tx_state_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] left;
    logic [DEFAULT_DATA_WIDTH-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo-frame FIFO with registered occupancy; shared by the DAC and ADC paths.
module audio_sample_fifo
  import mixer_audio_pkg::*;
#(
  parameter int FRAME_WIDTH = 2 * DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [FRAME_WIDTH-1:0]        push_data,
  input  logic                          pop,
  output logic [FRAME_WIDTH-1:0]        pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   LEVEL_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LEVEL_MAX = (PTR_W + 1)'(FIFO_DEPTH);

  logic [FRAME_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   push_en;
  logic                   pop_en;

  // Requests against a full or empty FIFO are silently dropped.
  assign full     = (level == LEVEL_MAX);
  assign empty    = (level == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_en && !pop_en)      level <= level + LEVEL_ONE;
      else if (pop_en && !push_en) level <= level - LEVEL_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmitter slaved to codec BCLK/DACLRCK: buffers stereo frames and shifts them out MSB-first.
module audio_dac_serializer
  import mixer_audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          audio_external_BCLK,
  input  logic                          audio_external_DACLRCK,
  output logic                          audio_external_DACDAT,
  input  logic [DATA_WIDTH-1:0]         sample_left,
  input  logic [DATA_WIDTH-1:0]         sample_right,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]              bclk_sync;
  logic [2:0]              lrck_sync;
  logic                    bclk_fall;
  logic                    lrck_fall;
  logic                    lrck_rise;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [2*DATA_WIDTH-1:0] pop_frame;
  tx_state_t               state;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   shadow_reg;
  logic [CNT_W-1:0]        bit_cnt;

  // Bits [1:0] are the two synchronizer stages; bit 2 is the previous synchronized value.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], audio_external_BCLK};
      lrck_sync <= {lrck_sync[1:0], audio_external_DACLRCK};
    end
  end

  assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
  assign lrck_fall = lrck_sync[2] & ~lrck_sync[1];
  assign lrck_rise = ~lrck_sync[2] & lrck_sync[1];

  assign sample_ready = !fifo_full;

  audio_sample_fifo #(
    .FRAME_WIDTH (2 * DATA_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clk_clk),
    .reset     (reset_reset),
    .push      (sample_valid),
    .push_data ({sample_left, sample_right}),
    .pop       (lrck_fall),
    .pop_data  (pop_frame),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // LRCK edges win over a coincident BCLK fall, which gives the one-bit I2S delay slot.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state                 <= IDLE;
      shift_reg             <= '0;
      shadow_reg            <= '0;
      bit_cnt               <= '0;
      audio_external_DACDAT <= 1'b0;
      underflow             <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (lrck_fall) begin
        state                 <= LEFT;
        bit_cnt               <= '0;
        audio_external_DACDAT <= 1'b0;
        if (!fifo_empty) begin
          shift_reg  <= pop_frame[2*DATA_WIDTH-1:DATA_WIDTH];
          shadow_reg <= pop_frame[DATA_WIDTH-1:0];
        end else begin
          shift_reg  <= '0;
          shadow_reg <= '0;
          underflow  <= 1'b1;
        end
      end else if (lrck_rise && state == LEFT) begin
        state                 <= RIGHT;
        shift_reg             <= shadow_reg;
        bit_cnt               <= '0;
        audio_external_DACDAT <= 1'b0;
      end else if (bclk_fall && state != IDLE) begin
        if (bit_cnt < CNT_DONE) begin
          audio_external_DACDAT <= shift_reg[DATA_WIDTH-1];
          shift_reg             <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
          bit_cnt               <= bit_cnt + CNT_ONE;
        end else begin
          audio_external_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized bench for audio_dac_serializer: a queue-of-frames model predicts FIFO occupancy and every I2S bit slot.
module tb_audio_dac_serializer;
  import mixer_audio_pkg::*;

  localparam int W     = DEFAULT_DATA_WIDTH;
  localparam int DEPTH = 4;

  logic         clk_clk = 1'b0;
  logic         reset_reset;
  logic         bclk;
  logic         lrck;
  logic         dacdat;
  logic [W-1:0] sample_left;
  logic [W-1:0] sample_right;
  logic         sample_valid;
  logic         sample_ready;
  logic [2:0]   fifo_level;
  logic         underflow;

  audio_dac_serializer #(
    .DATA_WIDTH (W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_clk                (clk_clk),
    .reset_reset            (reset_reset),
    .audio_external_BCLK    (bclk),
    .audio_external_DACLRCK (lrck),
    .audio_external_DACDAT  (dacdat),
    .sample_left            (sample_left),
    .sample_right           (sample_right),
    .sample_valid           (sample_valid),
    .sample_ready           (sample_ready),
    .fifo_level             (fifo_level),
    .underflow              (underflow)
  );

  always #10 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: frames queued in order, popped 3 clocks after each DACLRCK pin fall.
  stereo_frame_t model_q[$];
  stereo_frame_t cur_frame = '0;
  bit            tx_active = 1'b0;
  bit            exp_underflow = 1'b0;
  bit            lrck_prev = 1'b1;
  int            pop_pending = 0;
  int            pop_count = 0;
  int            uf_count = 0;
  bit            check_en = 1'b0;

  always @(posedge clk_clk) begin : model_blk
    int pre_size;
    bit do_pop;
    bit accept;
    pre_size      = model_q.size();
    do_pop        = 1'b0;
    exp_underflow = 1'b0;
    if (reset_reset) begin
      model_q.delete();
      tx_active   = 1'b0;
      pop_pending = 0;
      cur_frame   = '0;
    end else begin
      if (pop_pending > 0) begin
        pop_pending--;
        do_pop = (pop_pending == 0);
      end
      if (lrck_prev && !lrck) pop_pending = 2;
      accept = sample_valid && (pre_size < DEPTH);
      if (do_pop) begin
        pop_count++;
        tx_active = 1'b1;
        if (pre_size > 0) cur_frame = model_q.pop_front();
        else begin
          cur_frame     = '0;
          exp_underflow = 1'b1;
        end
      end
      if (accept) model_q.push_back({sample_left, sample_right});
    end
    lrck_prev = lrck;
  end

  always @(negedge clk_clk) begin
    if (check_en) begin
      checkOutput("level", 32'(fifo_level), 32'(model_q.size()));
      checkOutput("ready", 32'(sample_ready), 32'(model_q.size() < DEPTH));
      checkOutput("underflow", 32'(underflow), 32'(exp_underflow));
      if (underflow === 1'b1) uf_count++;
    end
  end

  // Codec clock generator (16 clk per BCLK) with a receiver that samples DACDAT on each BCLK rise.
  int bpc = 32;
  int bit_idx = 31;
  int phase = 0;
  bit gen_enable = 1'b0;
  bit gen_idle = 1'b1;

  initial begin : codec_gen
    logic [W-1:0] word;
    logic         exp_bit;
    bclk = 1'b1;
    lrck = 1'b1;
    forever begin
      @(negedge clk_clk);
      if (phase == 0 && (gen_idle || (!gen_enable && lrck && bit_idx == bpc - 1))) begin
        if (gen_enable) begin
          gen_idle = 1'b0;
          bit_idx  = bpc - 1;
        end else begin
          gen_idle = 1'b1;
        end
      end
      if (!gen_idle) begin
        if (phase == 0) begin
          bclk = 1'b0;
          bit_idx++;
          if (bit_idx == bpc) begin
            bit_idx = 0;
            lrck    = ~lrck;
          end
        end else if (phase == 8) begin
          bclk    = 1'b1;
          exp_bit = 1'b0;
          if (tx_active && bit_idx >= 1 && bit_idx <= W) begin
            word    = lrck ? cur_frame.right : cur_frame.left;
            exp_bit = word[W - bit_idx];
          end
          checkOutput($sformatf("dacdat_%s%0d", lrck ? "R" : "L", bit_idx), 32'(dacdat), 32'(exp_bit));
        end
        phase = (phase + 1) % 16;
      end
    end
  end

  task automatic applyStimulus(input bit valid, input logic [W-1:0] left, input logic [W-1:0] right);
    sample_valid = valid;
    sample_left  = left;
    sample_right = right;
    @(negedge clk_clk);
  endtask

  task automatic waitPops(input int target, input int budget);
    int n = 0;
    while (pop_count < target && n < budget) begin
      applyStimulus(1'b0, '0, '0);
      n++;
    end
    if (pop_count < target) checkOutput("pop_timeout", 32'(pop_count), 32'(target));
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    gen_enable = 1'b0;
    while (!gen_idle && n < budget) begin
      applyStimulus(1'b0, '0, '0);
      n++;
    end
    if (!gen_idle) checkOutput("idle_timeout", 32'(gen_idle), 32'd1);
  endtask

  initial begin
    int n;
    int uf_before;
    int permil;
    reset_reset  = 1'b1;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;
    repeat (3) @(negedge clk_clk);
    checkOutput("rst_dacdat", 32'(dacdat), 32'd0);
    checkOutput("rst_ready", 32'(sample_ready), 32'd1);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_underflow", 32'(underflow), 32'd0);
    reset_reset = 1'b0;
    check_en    = 1'b1;

    // Basic frame followed by an underflow frame.
    applyStimulus(1'b1, 16'hA5C3, 16'h0F01);
    applyStimulus(1'b0, '0, '0);
    uf_before  = uf_count;
    gen_enable = 1'b1;
    waitPops(1, 2000);
    waitPops(2, 2000);
    waitIdle(3000);
    checkOutput("underflow_pulses", 32'(uf_count - uf_before), 32'd1);

    // Five back-to-back pushes into a four-deep FIFO with LRCK stopped.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, W'($urandom), W'($urandom));
    applyStimulus(1'b0, '0, '0);
    checkOutput("full_ready", 32'(sample_ready), 32'd0);
    checkOutput("full_level", 32'(fifo_level), 32'd4);
    gen_enable = 1'b1;
    waitPops(pop_count + 1, 2000);
    checkOutput("after_pop_level", 32'(fifo_level), 32'd3);
    checkOutput("after_pop_ready", 32'(sample_ready), 32'd1);

    // Push in the very cycle of a pop with two frames stored.
    waitPops(pop_count + 1, 2000);
    n = 0;
    while (pop_pending != 1 && n < 3000) begin
      applyStimulus(1'b0, '0, '0);
      n++;
    end
    if (pop_pending != 1) checkOutput("simul_timeout", 32'(pop_pending), 32'd1);
    checkOutput("simul_level_before", 32'(fifo_level), 32'd2);
    applyStimulus(1'b1, W'($urandom), W'($urandom));
    sample_valid = 1'b0;
    checkOutput("simul_level_after", 32'(fifo_level), 32'd2);

    // Reset during bit 7 of the left word just popped.
    repeat (146) applyStimulus(1'b0, '0, '0);
    reset_reset = 1'b1;
    applyStimulus(1'b0, '0, '0);
    reset_reset = 1'b0;
    checkOutput("midrst_dacdat", 32'(dacdat), 32'd0);
    checkOutput("midrst_level", 32'(fifo_level), 32'd0);
    n = 0;
    while (lrck !== 1'b1 && n < 2000) begin
      applyStimulus(1'b0, '0, '0);
      n++;
    end
    applyStimulus(1'b1, W'($urandom), W'($urandom));
    waitPops(pop_count + 1, 2000);
    waitIdle(3000);

    // Short channel period: 12 BCLK per channel truncates each word.
    bpc = 12;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'($urandom), W'($urandom));
    applyStimulus(1'b0, '0, '0);
    uf_before  = uf_count;
    gen_enable = 1'b1;
    waitPops(pop_count + 3, 2000);
    waitIdle(3000);
    checkOutput("short_no_underflow", 32'(uf_count - uf_before), 32'd0);

    // Random traffic at normal channel length with idle, sparse and heavy push rates.
    bpc        = 32;
    gen_enable = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      permil = (blk % 3 == 0) ? 0 : ((blk % 3 == 1) ? 2 : 100);
      for (int c = 0; c < 1024; c++)
        applyStimulus($urandom_range(0, 999) < permil, W'($urandom), W'($urandom));
    end
    sample_valid = 1'b0;
    waitIdle(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Transmit side of the codec audio path: accepts stereo PCM samples from the mixer datapath over a valid/ready handshake and buffers them in a small FIFO. It shifts them out MSB-first on `audio_external_DACDAT` in I2S format, slaved to the codec-generated `BCLK` and `DACLRCK`. It sits between the mixing/effects pipeline and the codec DAC pins, mirroring the ADC capture path.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per channel sample; legal range 8..24.
- `FIFO_DEPTH`, 4: stereo frames buffered; power of two, at least 2.

Ports:
- `clk_clk`  in  1: system clock, 50 MHz nominal. Must be at least 8 times the `BCLK` frequency.
- `reset_reset`  in  1: synchronous, active-high reset.
- `audio_external_BCLK`  in  1: codec bit clock, asynchronous to `clk_clk`.
- `audio_external_DACLRCK`  in  1: codec word clock. Low selects left, high selects right. Asynchronous to `clk_clk`.
- `audio_external_DACDAT`  out  1: serial DAC data.
- `sample_left`  in  DATA_WIDTH: left sample, two's complement.
- `sample_right`  in  DATA_WIDTH: right sample, two's complement.
- `sample_valid`  in  1: a stereo frame is offered.
- `sample_ready`  out  1: the FIFO can accept a frame.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of frames stored.
- `underflow`  out  1: one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- **Synchronisation.** `BCLK` and `DACLRCK` each pass through a 2-flop synchronizer with the same depth. The synchronized values are then edge-detected against a third flop. Detected events:
  - `bclk_fall`: falling edge of `BCLK`.
  - `lrck_fall`: falling edge of `DACLRCK`, start of the left channel.
  - `lrck_rise`: rising edge of `DACLRCK`, start of the right channel.
- **Handshake.** `sample_ready = !full`. A push happens when `sample_valid && sample_ready`. Push and pop in the same cycle leave `fifo_level` unchanged. When full, `sample_ready` is 0 and `sample_valid` is ignored.
- **State machine.** States are IDLE, LEFT, RIGHT.
  - IDLE: all events are ignored until `lrck_fall`, which moves to LEFT.
  - LEFT: `lrck_rise` moves to RIGHT.
  - RIGHT: `lrck_fall` moves to LEFT.
- **Frame fetch on `lrck_fall`.**
  - If the FIFO is not empty, pop one frame. Load `sample_left` into the shift register and hold `sample_right` in a shadow register.
  - If the FIFO is empty, load zero into both and pulse `underflow`.
- **Right channel.** On `lrck_rise`, the shadow register is loaded into the shift register.
- **Bit shifting.**
  - On any LRCK edge, the bit counter is cleared and `DACDAT` is held at 0. This covers the one-BCLK I2S delay slot.
  - On each following `bclk_fall` with the counter below `DATA_WIDTH`: `DACDAT` takes the shift-register MSB, the register shifts left, and the counter increments.
  - Once the counter equals `DATA_WIDTH`, `DACDAT` stays 0 until the next LRCK edge.
- **Simultaneous events.** `bclk_fall` in the same cycle as an LRCK edge does not shift. The LRCK edge handling takes priority.
- **Short channel period.** If an LRCK edge arrives before `DATA_WIDTH` bits have been sent, the current word is truncated and the new channel is loaded. No error is flagged.
- **Reset mid-operation.** The FIFO is flushed and the state returns to IDLE. Output stays silent until the next `lrck_fall`; no partial word is ever sent.

## Timing
- **Reset values.**
  - `audio_external_DACDAT` = 0.
  - `sample_ready` = 1.
  - `fifo_level` = 0.
  - `underflow` = 0.
  - State = IDLE, counter = 0, shift and shadow registers = 0.
- **Pin-to-data latency.** `DACDAT` changes exactly 3 `clk_clk` cycles after the `BCLK` pin falling edge: 2 synchronizer stages plus 1 output register. This must be less than half a `BCLK` period, which the minimum clock ratio guarantees.
- **Pop and underflow latency.** The FIFO pop and the `underflow` pulse occur in the cycle `lrck_fall` is detected, i.e. 3 cycles after the `DACLRCK` pin edge.
- **Ready and level latency.**
  - `sample_ready` and `fifo_level` update in the cycle after the push or pop.
  - A push while at `FIFO_DEPTH-1` drives `sample_ready` low on the next cycle.
- **Outputs.** All outputs are registered. There is no combinational path from input to output.

## Structure
- **Package `mixer_audio_pkg`:**
  - the `DATA_WIDTH` default constant;
  - the `tx_state_t` enum (IDLE, LEFT, RIGHT);
  - the `stereo_frame_t` packed struct (`left`, `right`), shared with the ADC capture block.
- **Sub-module `audio_sample_fifo`:**
  - synchronous stereo FIFO with push/pop and level outputs;
  - parameterized by `FIFO_DEPTH`;
  - reused by the capture path.
- **Inline logic:** the synchronizers, edge detectors, state machine and shifter live in the top module.

## Test plan
- **Common stimulus.** `clk` 50 MHz; `BCLK` period 16 clk; `DACLRCK` 32 BCLK per channel.
- **Basic frame.** Push L=16'hA5C3, R=16'h0F01, then one LRCK period. `DACDAT` carries 1010_0101_1100_0011 starting on the 2nd BCLK fall after the LRCK fall. It carries 0000_1111_0000_0001 after the LRCK rise, and 0 outside the data bits.
- **Underflow.** Empty FIFO at `lrck_fall`. `underflow` pulses for exactly 1 cycle and all 64 bit slots of `DACDAT` are 0.
- **Full FIFO.** Push 5 frames back-to-back with no LRCK activity. 4 are accepted, `sample_ready` goes to 0 after the 4th, and `fifo_level` = 4. After one `lrck_fall`, `fifo_level` = 3 and `sample_ready` = 1.
- **Simultaneous push and pop.** Push on the same cycle as `lrck_fall` with `fifo_level` = 2. `fifo_level` stays 2 and the popped frame is the oldest one.
- **Reset mid-word.**
  - Stimulus: assert `reset_reset` for 1 cycle during bit 7 of the left channel.
  - Required response: `DACDAT` = 0 from the next cycle and `fifo_level` = 0.
  - Required response: no data on the subsequent `lrck_rise`; transmission resumes only after the next `lrck_fall` with a newly pushed frame.
- **Short channel period.** 12 BCLK per channel with `DATA_WIDTH` = 16. Only the 11 MSBs of each word are sent, words are truncated without a pulse on `underflow`, and the following frame aligns correctly.
